reg_file_mp_sb: RTL

Parametrised multi-port integer register file with a per-register busy scoreboard. It replaces the single-write, two-read register file in the Balotelli pipeline. Decode reads operands from it, and each in-flight producer marks its destination busy at issue. Write-back retires results and clears busy bits, and an exception flush clears the whole scoreboard.

---
 rtl/reg_file_mp_sb.sv | 125 ++++++++++++
 1 files changed

// File: rtl/reg_file_mp_sb.sv
// Multi-port register file with per-register busy scoreboard; x0 reads zero and is never busy.
// Reads are combinational from stored state; optional same-cycle write forwarding under REGFILE_BYPASS_EN.
module reg_file_mp_sb #(
    parameter int DATA_W   = 64,
    parameter int REG_NUM  = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [RD_PORTS-1:0]          RdEn,
    input  logic [RD_PORTS*ADDR_W-1:0]   RdAddr,
    output logic [RD_PORTS*DATA_W-1:0]   RdData,
    output logic [RD_PORTS-1:0]          RdBusy,
    input  logic [WR_PORTS-1:0]          WrEn,
    input  logic [WR_PORTS*ADDR_W-1:0]   WrAddr,
    input  logic [WR_PORTS*DATA_W-1:0]   WrData,
    input  logic                         ExcStopRegfile,
    input  logic                         IssueEn,
    input  logic [ADDR_W-1:0]            IssueAddr,
    input  logic                         SbFlush
);

    logic [DATA_W-1:0]  regs [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_nxt;
    logic [WR_PORTS-1:0] wr_commit;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < 32'(REG_NUM));
    endfunction

    always_comb begin
        wr_commit = '0;
        for (int j = 0; j < WR_PORTS; j++) begin
            wr_commit[j] = WrEn[j] && !ExcStopRegfile && addr_ok(WrAddr[j*ADDR_W +: ADDR_W]);
        end
    end

    // Ascending port loop: the highest-index committing port lands last and wins.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < WR_PORTS; j++) begin
                if (wr_commit[j]) begin
                    regs[WrAddr[j*ADDR_W +: ADDR_W]] <= WrData[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Statement order encodes priority: flush over issue over retire.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < WR_PORTS; j++) begin
            if (wr_commit[j]) begin
                busy_nxt[WrAddr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (IssueEn && addr_ok(IssueAddr)) begin
            busy_nxt[IssueAddr] = 1'b1;
        end
        if (SbFlush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic              last_iss_vld;
    logic [ADDR_W-1:0] last_iss_addr;

    // Remembers last cycle's issue so a retiring older producer cannot mask the new one.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            last_iss_vld  <= 1'b0;
            last_iss_addr <= '0;
        end else begin
            last_iss_vld  <= IssueEn && addr_ok(IssueAddr);
            last_iss_addr <= IssueAddr;
        end
    end
`endif

    always_comb begin : rd_path
        logic [ADDR_W-1:0] ra;
        logic              hit;
        RdData = '0;
        RdBusy = '0;
        ra     = '0;
        hit    = 1'b0;
        for (int i = 0; i < RD_PORTS; i++) begin
            ra  = RdAddr[i*ADDR_W +: ADDR_W];
            hit = 1'b0;
            if (RdEn[i] && addr_ok(ra)) begin
                RdData[i*DATA_W +: DATA_W] = regs[ra];
                RdBusy[i]                  = busy[ra];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < WR_PORTS; j++) begin
                    if (wr_commit[j] && (WrAddr[j*ADDR_W +: ADDR_W] == ra)) begin
                        RdData[i*DATA_W +: DATA_W] = WrData[j*DATA_W +: DATA_W];
                        hit = 1'b1;
                    end
                end
                if (hit) begin
                    RdBusy[i] = busy[ra] && last_iss_vld && (last_iss_addr == ra);
                end
`endif
            end
        end
    end

endmodule
